// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_if
// Brief    : Bundles the fetch, data and memory-side signals of the
//            unified memory arbiter. The arbiter connects to the slave modport.
//            The requesters and the memory model connect to the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    // data (load/store) port
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    // pipeline hazard lines
    logic              stall_if;
    logic              stall_mem;

    // single-port memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Shares one single-port unified memory between the IF and MEM
//            stages with a fixed-latency access FSM.
//            Optional build macro: ARB_ROUND_ROBIN_EN selects alternating
//            grants instead of fixed data priority.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input wire clk,
    input wire reset,
    unified_mem_arbiter_if.slave bus
);

    localparam int c_CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_is_store;
    logic                w_is_store_nxt;
    logic                r_mem_en;
    logic                w_mem_en_nxt;
    logic                r_mem_we;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                r_if_ack;
    logic                w_if_ack_nxt;
    logic                r_d_ack;
    logic                w_d_ack_nxt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   w_if_rdata_nxt;
    logic [DATA_W-1:0]   r_d_rdata;
    logic [DATA_W-1:0]   w_d_rdata_nxt;

    logic                w_d_pend;
    logic                w_grant_d;
    logic                w_grant_i;

    assign w_d_pend = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 0: data was granted last, 1: fetch was granted last
    logic r_last_grant;

    assign w_grant_d = w_d_pend & (~bus.if_req | r_last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (r_state == S_IDLE && (w_grant_d || w_grant_i)) begin
            r_last_grant <= w_grant_i;
        end
    end
`else
    assign w_grant_d = w_d_pend;
`endif

    assign w_grant_i = bus.if_req & ~w_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_store  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_store  <= w_is_store_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_store_nxt  = r_is_store;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    // a simultaneous read+write is issued as a store
                    w_state_nxt     = S_BUSY_D;
                    w_cnt_nxt       = c_CNT_LOAD;
                    w_is_store_nxt  = bus.d_write;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = bus.d_write;
                    w_mem_addr_nxt  = bus.d_addr;
                    w_mem_wdata_nxt = bus.d_wdata;
                end else if (w_grant_i) begin
                    w_state_nxt     = S_BUSY_I;
                    w_cnt_nxt       = c_CNT_LOAD;
                    w_is_store_nxt  = 1'b0;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_addr_nxt  = bus.if_addr;
                end
            end
            S_BUSY_I: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_if_rdata_nxt = bus.mem_rdata;
                    w_if_ack_nxt   = 1'b1;
                    w_state_nxt    = S_DONE;
                end
            end
            S_BUSY_D: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    if (!r_is_store) begin
                        w_d_rdata_nxt = bus.mem_rdata;
                    end
                    w_d_ack_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // requester still holds its request during the ack cycle
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

    assign bus.stall_if  = bus.if_req & ~r_if_ack;
    assign bus.stall_mem = w_d_pend & ~r_d_ack;

endmodule
`default_nettype wire
